// File: rtl/rysy_mem.sv
// rysy_mem: unified program/data RAM plus a small MMIO window (GPIO out, cycle counter, GPIO in).
// Latency: every cycle is a read; rdata is registered, so it is valid one cycle after addr.
// Backpressure: none. The core's single port is serviced every cycle, and writes complete on the edge.
// Ports: clk/rst (async active-high), addr/wdata/we/be from the core, rdata to the core,
//        gpio_in (asynchronous, synchronised internally), gpio_out register, bus_err pulse.
module rysy_mem #(
    parameter int          DEPTH     = 1024,
    parameter              INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              bus_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [31:0]       rdata_q, rdata_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic              bus_err_q, bus_err_d;

    logic          ram_hit, gpo_hit, cnt_hit, gpi_hit, unmapped;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_wr_word;
    logic [31:0]   gpo_ext, gpi_ext, gpo_wr_word;
    logic          unused_ok;

    // Word-granular decode; addr[1:0] plays no part.
    always_comb begin
        ram_hit  = (addr[31:AW+2] == '0);
        gpo_hit  = (addr[31:2] == MMIO_BASE[31:2]);
        cnt_hit  = (addr[31:2] == (MMIO_BASE[31:2] + 30'd1));
        gpi_hit  = (addr[31:2] == (MMIO_BASE[31:2] + 30'd2));
        unmapped = !(ram_hit || gpo_hit || cnt_hit || gpi_hit);
        ram_idx  = addr[AW+1:2];
    end

    // Byte-lane merge shared by the RAM word and the GPIO output register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        gpo_ext                 = '0;
        gpo_ext[GPIO_W-1:0]     = gpio_q;
        gpi_ext                 = '0;
        gpi_ext[GPIO_W-1:0]     = sync2_q;
        ram_wr_word             = merge_bytes(mem[ram_idx], wdata, be);
        gpo_wr_word             = merge_bytes(gpo_ext, wdata, be);

        gpio_d = gpio_q;
        if (we && gpo_hit) gpio_d = gpo_wr_word[GPIO_W-1:0];

        cnt_d     = cnt_q + 32'd1;
        bus_err_d = unmapped;

        // Sources are sampled before this edge's updates, so a read
        // that coincides with a write returns the old value.
        rdata_d = 32'h0;
        if (ram_hit)      rdata_d = mem[ram_idx];
        else if (gpo_hit) rdata_d = gpo_ext;
        else if (cnt_hit) rdata_d = cnt_q;
        else if (gpi_hit) rdata_d = gpi_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= 32'h0000_0013;
            gpio_q    <= '0;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            gpio_q    <= gpio_d;
            cnt_q     <= cnt_d;
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            bus_err_q <= bus_err_d;
        end
    end

    // RAM is not reset; a write landing on an edge while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we && ram_hit) mem[ram_idx] <= ram_wr_word;
    end

    assign unused_ok = ^{addr[1:0], gpo_wr_word};

    assign rdata    = rdata_q;
    assign gpio_out = gpio_q;
    assign bus_err  = bus_err_q;

endmodule
